// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity framer.
package serial_parity_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      PAR  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ACC_HOLD = 2'd0,
      ACC_LOAD = 2'd1,
      ACC_STEP = 2'd2,
      ACC_CLR  = 2'd3
   } acc_op_t;

   localparam logic MODE_GEN = 1'b0;
   localparam logic MODE_CHK = 1'b1;
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_acc.sv
// Running-parity register and data-bit counter for one frame.
module serial_parity_acc
   import serial_parity_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic    i_clk,
   input  logic    i_rst,
   input  acc_op_t i_op,
   input  logic    i_x,
   output logic    o_par,
   output logic    o_par_nxt,
   output logic    o_last,
   output logic    o_last_nxt
);

   localparam int CNT_W = $clog2(DATA_BITS + 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt   <= '0;
         o_par <= 1'b0;
      end else begin
         case (i_op)
            ACC_LOAD: begin
               cnt   <= CNT_W'(1);
               o_par <= i_x;
            end
            ACC_STEP: begin
               cnt   <= cnt + CNT_W'(1);
               o_par <= o_par ^ i_x;
            end
            ACC_CLR: begin
               cnt   <= '0;
               o_par <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // par is kept at 0 while idle, so par^x is also the frame's first-bit parity
   assign o_par_nxt  = o_par ^ i_x;
   assign o_last     = (cnt == CNT_W'(DATA_BITS));
   assign o_last_nxt = (cnt == CNT_W'(DATA_BITS - 1));

endmodule

// File: rtl/serial_parity_framer.sv
// Framed serial parity generator/checker.
// Optional SERIAL_PARITY_STICKY_ERR_EN adds i_err_clr / o_err_sticky.
module serial_parity_framer
   import serial_parity_pkg::*;
#(
   parameter int DATA_BITS = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_x,
   input  logic i_valid,
   input  logic i_odd,
   input  logic i_mode,
   output logic o_p,
   output logic o_done,
   output logic o_err,
   output logic o_busy
`ifdef SERIAL_PARITY_STICKY_ERR_EN
   ,
   input  logic i_err_clr,
   output logic o_err_sticky
`endif
);

   state_t  state, state_n;
   acc_op_t op;
   logic    mode_q, odd_q, latch;
   logic    mode_eff, odd_eff, exp_par;
   logic    par, par_nxt, last, last_nxt;
   logic    p_n, done_n, err_n;

   serial_parity_acc #(.DATA_BITS(DATA_BITS)) u_acc (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_op       (op),
      .i_x        (i_x),
      .o_par      (par),
      .o_par_nxt  (par_nxt),
      .o_last     (last),
      .o_last_nxt (last_nxt)
   );

   // A frame starting this cycle takes mode/sense from the live inputs
   assign mode_eff = (state == IDLE) ? i_mode : mode_q;
   assign odd_eff  = (state == IDLE) ? i_odd  : odd_q;
   assign exp_par  = par ^ odd_q;

   always_comb begin
      state_n = state;
      op      = ACC_HOLD;
      latch   = 1'b0;
      done_n  = 1'b0;
      p_n     = o_p;
      err_n   = o_err;
      case (state)
         IDLE, DATA: begin
            if (i_valid) begin
               latch = (state == IDLE);
               op    = (state == IDLE) ? ACC_LOAD : ACC_STEP;
               if (!last_nxt) begin
                  state_n = DATA;
               end else if (mode_eff == MODE_GEN) begin
                  op      = ACC_CLR;
                  state_n = IDLE;
                  done_n  = 1'b1;
                  p_n     = par_nxt ^ odd_eff;
                  err_n   = 1'b0;
               end else begin
                  state_n = PAR;
               end
            end
         end
         PAR: begin
            if (i_valid && last) begin
               op      = ACC_CLR;
               state_n = IDLE;
               done_n  = 1'b1;
               p_n     = exp_par;
               err_n   = i_x ^ exp_par;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state  <= IDLE;
         mode_q <= MODE_GEN;
         odd_q  <= PAR_EVEN;
         o_p    <= 1'b0;
         o_done <= 1'b0;
         o_err  <= 1'b0;
         o_busy <= 1'b0;
      end else begin
         state  <= state_n;
         o_p    <= p_n;
         o_done <= done_n;
         o_err  <= err_n;
         o_busy <= (state_n != IDLE);
         if (latch) begin
            mode_q <= i_mode;
            odd_q  <= i_odd;
         end
      end
   end

`ifdef SERIAL_PARITY_STICKY_ERR_EN
   // Set has priority over a coincident clear
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                o_err_sticky <= 1'b0;
      else if (done_n && err_n) o_err_sticky <= 1'b1;
      else if (i_err_clr)       o_err_sticky <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_serial_parity_framer.sv
// Directed table-driven bench for serial_parity_framer (DATA_BITS=8 and DATA_BITS=1).
module tb_serial_parity_framer;
   import serial_parity_pkg::*;

   logic i_clk, i_rst;
   logic i_x, i_valid, i_odd, i_mode;
   logic o_p, o_done, o_err, o_busy;
   logic x1, v1, odd1, mode1;
   logic p1, done1, err1, busy1;
`ifdef SERIAL_PARITY_STICKY_ERR_EN
   logic err_clr, sticky, err_clr1, sticky1;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   serial_parity_framer #(.DATA_BITS(8)) dut (
      .i_clk (i_clk), .i_rst (i_rst), .i_x (i_x), .i_valid (i_valid),
      .i_odd (i_odd), .i_mode (i_mode),
      .o_p (o_p), .o_done (o_done), .o_err (o_err), .o_busy (o_busy)
`ifdef SERIAL_PARITY_STICKY_ERR_EN
      , .i_err_clr (err_clr), .o_err_sticky (sticky)
`endif
   );

   serial_parity_framer #(.DATA_BITS(1)) dut1 (
      .i_clk (i_clk), .i_rst (i_rst), .i_x (x1), .i_valid (v1),
      .i_odd (odd1), .i_mode (mode1),
      .o_p (p1), .o_done (done1), .o_err (err1), .o_busy (busy1)
`ifdef SERIAL_PARITY_STICKY_ERR_EN
      , .i_err_clr (err_clr1), .o_err_sticky (sticky1)
`endif
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time budget");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic       mode;
      logic       odd;
      logic [7:0] data;
      logic       rp;
      logic       tog;
      logic       exp_p;
      logic       exp_e;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string nm, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Sends one frame MSB-first (plus rp in check mode); optional 3-cycle stall before bit stall_at
   task automatic run_frame(input logic mode, input logic odd, input logic [7:0] data,
                            input logic rp, input logic tog, input int stall_at,
                            input logic exp_p, input logic exp_e);
      int nb;
      nb = (mode == MODE_CHK) ? 9 : 8;
      for (int i = 0; i < nb; i++) begin
         if (i == stall_at) begin
            repeat (3) begin
               @(negedge i_clk);
               i_valid = 1'b0;
               i_x     = ~i_x;
               check("stall_busy", o_busy, 1'b1);
               check("stall_done", o_done, 1'b0);
            end
         end
         @(negedge i_clk);
         check("frame_busy", o_busy, (i != 0));
         check("frame_no_done", o_done, 1'b0);
         i_valid = 1'b1;
         i_x     = (i < 8) ? data[7-i] : rp;
         i_mode  = (tog && i > 0) ? ~mode : mode;
         i_odd   = (tog && i > 0) ? ~odd  : odd;
      end
      @(negedge i_clk);
      i_valid = 1'b0;
      check("done", o_done, 1'b1);
      check("p", o_p, exp_p);
      check("err", o_err, exp_e);
      check("busy_at_done", o_busy, 1'b0);
      @(negedge i_clk);
      check("done_pulse", o_done, 1'b0);
      check("p_hold", o_p, exp_p);
      check("err_hold", o_err, exp_e);
   endtask

   // Three back-to-back frames with i_valid held high throughout
   task automatic run_stream(input logic mode);
      logic [7:0] sd [3];
      logic [2:0] rp, ep, ee;
      int nb, f;
      sd = '{8'hB2, 8'hFE, 8'h01};
      rp = 3'b011;
      ep = 3'b110;
      ee = (mode == MODE_CHK) ? 3'b101 : 3'b000;
      nb = (mode == MODE_CHK) ? 9 : 8;
      for (int k = 0; k < 3 * nb; k++) begin
         @(negedge i_clk);
         if (k > 0 && (k % nb) == 0) begin
            f = k / nb - 1;
            check("stream_done", o_done, 1'b1);
            check("stream_p", o_p, ep[f]);
            check("stream_err", o_err, ee[f]);
         end else begin
            check("stream_gap", o_done, 1'b0);
         end
         i_valid = 1'b1;
         i_mode  = mode;
         i_odd   = PAR_EVEN;
         i_x     = ((k % nb) == 8) ? rp[k/nb] : sd[k/nb][7-(k%nb)];
      end
      @(negedge i_clk);
      i_valid = 1'b0;
      check("stream_done_last", o_done, 1'b1);
      check("stream_p_last", o_p, ep[2]);
      check("stream_err_last", o_err, ee[2]);
      @(negedge i_clk);
      check("stream_end", o_done, 1'b0);
   endtask

   initial begin
      logic [4:0] s1, o1, e1;

      tbl[0] = '{MODE_GEN, PAR_EVEN, 8'b10110010, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{MODE_GEN, PAR_ODD,  8'b10110010, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{MODE_CHK, PAR_EVEN, 8'b11100000, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{MODE_CHK, PAR_EVEN, 8'b11100000, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{MODE_GEN, PAR_EVEN, 8'b11111111, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{MODE_CHK, PAR_ODD,  8'b11100000, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{MODE_GEN, PAR_ODD,  8'b00000000, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{MODE_CHK, PAR_EVEN, 8'b00000001, 1'b0, 1'b0, 1'b1, 1'b1};

      i_rst = 1'b1; i_x = 1'b0; i_valid = 1'b0; i_odd = 1'b0; i_mode = 1'b0;
      x1 = 1'b0; v1 = 1'b0; odd1 = 1'b0; mode1 = 1'b0;
`ifdef SERIAL_PARITY_STICKY_ERR_EN
      err_clr = 1'b0; err_clr1 = 1'b0;
`endif
      #3;
      check("rst_p", o_p, 1'b0);
      check("rst_done", o_done, 1'b0);
      check("rst_err", o_err, 1'b0);
      check("rst_busy", o_busy, 1'b0);
      @(negedge i_clk);
      i_rst = 1'b0;

      for (int v = 0; v < 8; v++)
         run_frame(tbl[v].mode, tbl[v].odd, tbl[v].data, tbl[v].rp, tbl[v].tog, -1,
                   tbl[v].exp_p, tbl[v].exp_e);

`ifdef SERIAL_PARITY_STICKY_ERR_EN
      check("sticky_set", sticky, 1'b1);
      @(negedge i_clk);
      check("sticky_hold", sticky, 1'b1);
      err_clr = 1'b1;
      @(negedge i_clk);
      err_clr = 1'b0;
      check("sticky_clr", sticky, 1'b0);
`endif

      // Mid-frame asynchronous reset after 5 bits (last frame left o_p=1, o_err=1)
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         i_valid = 1'b1; i_mode = MODE_GEN; i_odd = PAR_EVEN;
         i_x = tbl[0].data[7-i];
      end
      @(negedge i_clk);
      i_valid = 1'b0;
      check("pre_rst_busy", o_busy, 1'b1);
      check("pre_rst_p", o_p, 1'b1);
      #2 i_rst = 1'b1;
      #1;
      check("arst_busy", o_busy, 1'b0);
      check("arst_p", o_p, 1'b0);
      check("arst_err", o_err, 1'b0);
      check("arst_done", o_done, 1'b0);
      @(negedge i_clk);
      i_rst = 1'b0;
      repeat (3) begin
         @(negedge i_clk);
         check("post_rst_no_done", o_done, 1'b0);
      end
      run_frame(MODE_GEN, PAR_EVEN, 8'hFF, 1'b0, 1'b0, -1, 1'b0, 1'b0);

      // Stall after bit 4
      run_frame(MODE_GEN, PAR_EVEN, 8'b10110010, 1'b0, 1'b0, 4, 1'b0, 1'b0);
      run_frame(MODE_CHK, PAR_ODD,  8'b11100000, 1'b1, 1'b0, 4, 1'b0, 1'b1);

      run_stream(MODE_GEN);
      run_stream(MODE_CHK);

      // DATA_BITS=1 generate: one completion per accepted bit
      s1 = 5'b11010;  // bits sent in order s1[4]..s1[0]: 1,1,0,1,0
      o1 = 5'b00011;  // odd sense per bit in same order: 0,0,0,1,1
      e1 = 5'b11001;  // expected o_p per bit: 1,1,0,0,1
      for (int k = 0; k < 5; k++) begin
         @(negedge i_clk);
         if (k == 0) check("db1_first", done1, 1'b0);
         else begin
            check("db1_done", done1, 1'b1);
            check("db1_p", p1, e1[5-k]);
         end
         check("db1_busy", busy1, 1'b0);
         v1 = 1'b1; mode1 = MODE_GEN;
         x1 = s1[4-k]; odd1 = o1[4-k];
      end
      @(negedge i_clk);
      v1 = 1'b0;
      check("db1_done_last", done1, 1'b1);
      check("db1_p_last", p1, e1[0]);
      @(negedge i_clk);
      check("db1_end", done1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_parity_framer.md
Name: serial_parity_framer

Overview:
Parametrised serial parity block for framed bit streams, succeeding the fixed single-bit even-parity FSM.
- Accepts one qualified serial bit per cycle and counts DATA_BITS per frame.
- Generate mode: emits the even or odd parity bit at frame end.
- Check mode: consumes a trailing received parity bit and flags mismatch.
- Sits between a serialiser/deserialiser and the UART-style framing logic.

Parameters:
DATA_BITS, 8, data bits per frame (>=1); localparam CNT_W = $clog2(DATA_BITS+1) sizes the bit counter.

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_x  input  1  serial data bit
i_valid  input  1  i_x qualifier; bit accepted on rising edge when high
i_odd  input  1  parity sense, 1=odd, 0=even; latched at frame start
i_mode  input  1  0=generate, 1=check; latched at frame start
o_p  output  1  parity bit of completed frame; valid when o_done=1
o_done  output  1  one-cycle pulse: frame complete
o_err  output  1  check mode only: received parity mismatch; valid with o_done
o_busy  output  1  frame in progress (at least one bit accepted, not yet complete)

Behaviour:
- Clock, reset and outputs:
  - One clock i_clk; reset i_rst is asynchronous, active-high.
  - All outputs registered; reset value 0 for o_p, o_done, o_err, o_busy.
  - Reset clears counter, running parity, latched mode/sense; FSM goes to IDLE.
- FSM states and transitions:
  - IDLE: bit counter 0. If i_valid: latch i_odd/i_mode, par<=i_x, cnt<=1, go DATA, unless the frame is already complete (DATA_BITS=1, gen mode).
  - DATA: each accepted bit: par<=par^i_x, cnt<=cnt+1. After DATA_BITS-th bit: gen mode -> IDLE with completion; check mode -> PAR.
  - PAR (check only): next accepted bit is received parity rp. Go IDLE with completion.
- Completion (registered, asserted the cycle after the final bit is accepted):
  - o_done=1 for exactly one cycle.
  - Gen mode: o_p = par ^ odd, so total ones incl. parity is even (odd=0) or odd (odd=1). o_err=0.
  - Check mode: o_p = expected parity; o_err = rp ^ expected.
  - o_p/o_err hold their value until the next completion or reset; o_done does not.
- o_busy is 1 from the cycle after the first bit until the cycle o_done asserts; it drops to 0 in that cycle.
- Latency: final bit edge -> o_done 1 cycle.
- Throughput: zero-bubble. A bit accepted in the o_done cycle starts the next frame.
- Stalls: i_valid=0 holds all state. No timeout.
- Mode/sense changes mid-frame are ignored until the next frame start.
- Reset mid-frame: immediate abort. No o_done is issued for the aborted frame, and the partial parity is discarded.
- Counter never exceeds DATA_BITS; no wrap-around within a frame.

Optional Feature:
SERIAL_PARITY_STICKY_ERR_EN
- With the macro defined:
  - Adds input i_err_clr (1) and output o_err_sticky (1).
  - o_err_sticky sets on any o_done with o_err=1 and stays set until i_err_clr=1 or reset.
  - If set and clear occur in the same cycle, set wins.
  - Reset value of o_err_sticky is 0.
- Without the macro: the ports and their logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package serial_parity_pkg holds:
  - state enum (IDLE, DATA, PAR)
  - MODE_GEN=1'b0, MODE_CHK=1'b1
  - PAR_EVEN=1'b0, PAR_ODD=1'b1
- One sub-module: serial_parity_acc.
  - Contents: running-parity register plus CNT_W bit counter.
  - Controls: load/accumulate/clear.
  - Outputs: par, last flag (cnt==DATA_BITS).
  - The top holds the FSM and output registers.

Test Plan:
1. Gen, even, DATA_BITS=8, bits 1,0,1,1,0,0,1,0 on 8 consecutive valid cycles -> next cycle o_done=1, o_p=0, o_err=0; o_busy 1 during frame only.
2. Same data, i_odd=1 -> o_p=1; toggling i_odd mid-frame has no effect on the result.
3. Check, even, data 1,1,1,0,0,0,0,0 then rp=1 -> o_done=1, o_err=0, o_p=1. Repeat with rp=0 -> o_err=1; with the macro, o_err_sticky=1 until i_err_clr.
4. Gen frame with i_valid low 3 cycles after bit 4 -> state frozen; o_done exactly 1 cycle after 8th accepted bit, correct o_p.
5. i_rst pulsed after 5 bits -> all outputs 0 asynchronously, no o_done. A fresh 8-bit frame 0xFF yields o_p=0 (even).
6. Continuous i_valid, 3 back-to-back frames -> o_done every 8 cycles (gen) or 9 (check), no dropped bits. DATA_BITS=1 gen: o_done every cycle after first, o_p=i_x^odd of the prior bit.
